vita49_unpack_arb: RTL and testbench
====================================

VITA49_UNPACK_ARB -- requirements
Module: vita49_unpack_arb

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of each per-port packet counter.
REQ-002 SHALL have parameter STALL_LIMIT, default 1024: number of consecutive starved cycles mid-packet before the stall flag sets.
REQ-003 SHALL have port AXIS_ACLK, input, 1: the single clock for all logic.
REQ-004 SHALL have port AXIS_ARESETN, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port S0_AXIS_TDATA, input, 32: requester 0 data.
REQ-006 SHALL have ports S0_AXIS_TVALID (input), S0_AXIS_TLAST (input) and S0_AXIS_TREADY (output), each 1: requester 0 handshake.
REQ-007 SHALL have ports S1_AXIS_TDATA, S1_AXIS_TVALID, S1_AXIS_TLAST and S1_AXIS_TREADY, with the same widths and directions as the S0 ports: requester 1.
REQ-008 SHALL have ports M_AXIS_TDATA (output, 32), M_AXIS_TVALID (output, 1), M_AXIS_TLAST (output, 1) and M_AXIS_TREADY (input, 1): the shared path to the unpacker.
REQ-009 SHALL have port port_en, input, 2: per-requester enable; bit n enables port n.
REQ-010 SHALL have port clr, input, 1: synchronous clear of the counters and the stall flags.
REQ-011 SHALL have ports pkt_cnt0 and pkt_cnt1, output, CNT_WIDTH each: completed packets per port.
REQ-012 SHALL have port stall_flag, output, 2: sticky per-port mid-packet starvation flag.
REQ-013 SHALL have port grant_dbg, output, 2: one-hot current grant, 00 when idle.
REQ-014 SHALL have port irq, output, 1: OR of the stall_flag bits.

Function
REQ-015 SHALL implement the FSM states IDLE, GNT0 and GNT1.
REQ-016 In IDLE, the requests SHALL be req0 = S0_AXIS_TVALID & port_en[0] and req1 = S1_AXIS_TVALID & port_en[1]; with exactly one request, the FSM SHALL move to that port's GNT state at the next clock edge.
REQ-017 In IDLE with both requests, the FSM SHALL grant the port not in last_grant (round-robin).
REQ-018 last_grant SHALL update on entry to each GNT state and SHALL reset to 1, so that port 0 wins the first tie.
REQ-019 In IDLE, the block SHALL drive both S*_AXIS_TREADY = 0 and M_AXIS_TVALID = 0.
REQ-020 In GNTn, M_AXIS_TDATA, M_AXIS_TVALID and M_AXIS_TLAST SHALL equal port n's signals combinationally (zero latency), Sn_AXIS_TREADY SHALL equal M_AXIS_TREADY, and the other port's TREADY SHALL be 0.
REQ-021 In GNTn, a beat with TVALID & TREADY & TLAST SHALL return the FSM to IDLE at the next edge and increment pkt_cntn by 1, wrapping modulo 2^CNT_WIDTH.
REQ-022 Each packet boundary SHALL cost exactly one IDLE cycle, giving a minimum of one bubble between packets.
REQ-023 Arbitration SHALL be packet-atomic: no switch of grant before the TLAST handshake.
REQ-024 Deasserting port_en[n] during GNTn SHALL NOT abort the packet; the packet completes and port n is then not granted again.
REQ-025 When M_AXIS_TREADY = 0, the block SHALL hold the grant with no bubble and no data loss, and the stall counter SHALL NOT advance.
REQ-026 The stall counter SHALL count cycles in GNTn with Sn_AXIS_TVALID = 0, SHALL reset to 0 on any port n beat and on leaving GNTn, and at STALL_LIMIT SHALL set stall_flag[n], which stays set until clr or reset; the grant SHALL be held.
REQ-027 clr SHALL zero both counters and stall_flag at the next edge; when clr and a counter increment fall in the same cycle, clr SHALL win.
REQ-028 A single-beat packet (TLAST on the first beat) SHALL be counted as 1 packet.
REQ-029 irq SHALL be registered: irq = |stall_flag, one cycle after the flag sets.

Reset
REQ-030 On AXIS_ARESETN low, asynchronously: FSM = IDLE, last_grant = 1, counters = 0, stall_flag = 0, stall counter = 0, irq = 0.
REQ-031 During reset, the block SHALL hold grant_dbg = 00, all TREADY = 0 and M_AXIS_TVALID = 0.
REQ-032 A reset mid-packet SHALL drop the remainder of the packet and SHALL NOT count it.
REQ-033 On release of reset, the first arbitration SHALL occur in the first cycle after release.

Verification
REQ-034 Both ports enabled, each sending continuous 4-beat packets, M_AXIS_TREADY = 1 -> output order S0, S1, S0, S1, 4 beats + 1 bubble per packet, pkt_cnt0 = pkt_cnt1 = 2 after 4 packets.
REQ-035 S1 mid-packet at beat 2, then S0 asserts TVALID -> S0 TREADY stays 0 until S1's TLAST handshake, and S0 is granted the cycle after the bubble.
REQ-036 In GNT0, S0_AXIS_TVALID low for STALL_LIMIT = 1024 cycles -> stall_flag = 01 at cycle 1024, irq = 1 one cycle later; clr -> both return to 0.
REQ-037 M_AXIS_TREADY toggling 1/0 every cycle over a 6-beat packet -> all 6 words delivered in order, TLAST on word 6, stall_flag stays 00.
REQ-038 pkt_cnt0 preloaded to 0xFFFF by 65535 packets, then one more packet -> pkt_cnt0 = 0x0000; clr coincident with a TLAST handshake -> counter = 0.
REQ-039 AXIS_ARESETN pulsed low at beat 3 of 8 -> outputs go to reset values immediately, the packet is not counted, and port 0 wins the next tie.

Source files
------------

// File: rtl/vita49_unpack_arb.sv
// vita49_unpack_arb: two-port, packet-atomic round-robin AXI-Stream arbiter
// feeding a single VITA-49 unpacker. The data path is purely combinational
// (zero latency) while granted. Each packet boundary returns through IDLE,
// which costs one bubble cycle.
// Also provides per-port completed-packet counters and a sticky
// mid-packet starvation flag with a registered interrupt.
module vita49_unpack_arb #(
    parameter int CNT_WIDTH   = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESETN,
    // requester 0
    input  logic [31:0]          S0_AXIS_TDATA,
    input  logic                 S0_AXIS_TVALID,
    input  logic                 S0_AXIS_TLAST,
    output logic                 S0_AXIS_TREADY,
    // requester 1
    input  logic [31:0]          S1_AXIS_TDATA,
    input  logic                 S1_AXIS_TVALID,
    input  logic                 S1_AXIS_TLAST,
    output logic                 S1_AXIS_TREADY,
    // shared output to the unpacker
    output logic [31:0]          M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    output logic                 M_AXIS_TLAST,
    input  logic                 M_AXIS_TREADY,
    // control / status
    input  logic [1:0]           port_en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
    output logic [1:0]           stall_flag,
    output logic [1:0]           grant_dbg,
    output logic                 irq
);

    // Wide enough to hold STALL_LIMIT itself; the counter saturates there.
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;   // index of the port granted most recently
    logic [CNT_WIDTH-1:0]  r_pkt_cnt0;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt1;
    logic [SC_W-1:0]       r_stall_cnt;
    logic [1:0]            r_stall_flag;
    logic                  r_irq;

    logic                  w_req0;
    logic                  w_req1;
    logic [31:0]           w_m_tdata;
    logic                  w_m_tvalid;
    logic                  w_m_tlast;
    logic                  w_s0_tready;
    logic                  w_s1_tready;
    logic                  w_beat;         // handshake on the granted port
    logic                  w_last_hs;      // handshake carrying TLAST
    logic                  w_starved;      // granted but source has nothing to send
    logic                  w_stall_hit;    // this cycle is the STALL_LIMIT-th starved one

    // Requests only matter in IDLE. A disabled port is never newly granted,
    // but a packet already in flight is allowed to finish.
    assign w_req0 = S0_AXIS_TVALID & port_en[0];
    assign w_req1 = S1_AXIS_TVALID & port_en[1];

    // Next-state and output mux: the granted port is wired straight through.
    always_comb begin
        w_state_nxt = r_state;
        w_m_tdata   = '0;
        w_m_tvalid  = 1'b0;
        w_m_tlast   = 1'b0;
        w_s0_tready = 1'b0;
        w_s1_tready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1)
                    w_state_nxt = r_last_grant ? GNT0 : GNT1;
                else if (w_req0)
                    w_state_nxt = GNT0;
                else if (w_req1)
                    w_state_nxt = GNT1;
            end
            GNT0: begin
                w_m_tdata   = S0_AXIS_TDATA;
                w_m_tvalid  = S0_AXIS_TVALID;
                w_m_tlast   = S0_AXIS_TLAST;
                w_s0_tready = M_AXIS_TREADY;
                if (S0_AXIS_TVALID && M_AXIS_TREADY && S0_AXIS_TLAST)
                    w_state_nxt = IDLE;
            end
            GNT1: begin
                w_m_tdata   = S1_AXIS_TDATA;
                w_m_tvalid  = S1_AXIS_TVALID;
                w_m_tlast   = S1_AXIS_TLAST;
                w_s1_tready = M_AXIS_TREADY;
                if (S1_AXIS_TVALID && M_AXIS_TREADY && S1_AXIS_TLAST)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_beat      = w_m_tvalid & M_AXIS_TREADY;
    assign w_last_hs   = w_beat & w_m_tlast;
    // A TVALID-high / TREADY-low cycle is downstream backpressure, not starvation.
    assign w_starved   = (r_state != IDLE) & ~w_m_tvalid;
    assign w_stall_hit = w_starved & (r_stall_cnt == SC_W'(STALL_LIMIT - 1));

    // FSM state register.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) r_state <= IDLE;
        else               r_state <= w_state_nxt;
    end

    // Remember the winner on every grant entry; reset value 1 lets port 0 win the first tie.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_last_grant <= 1'b1;
        end else if (r_state == IDLE) begin
            if (w_state_nxt == GNT0)      r_last_grant <= 1'b0;
            else if (w_state_nxt == GNT1) r_last_grant <= 1'b1;
        end
    end

    // Completed-packet counters; clr takes priority over a same-cycle increment.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else if (clr) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else if (w_last_hs) begin
            if (r_state == GNT0) r_pkt_cnt0 <= r_pkt_cnt0 + CNT_WIDTH'(1);
            if (r_state == GNT1) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_WIDTH'(1);
        end
    end

    // Starvation counter: one is enough since only one port is granted at a time.
    // Cleared in IDLE and on every beat, saturates at STALL_LIMIT so the flag
    // fires once per starvation episode.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN)
            r_stall_cnt <= '0;
        else if (r_state == IDLE || w_beat)
            r_stall_cnt <= '0;
        else if (w_starved && r_stall_cnt != SC_W'(STALL_LIMIT))
            r_stall_cnt <= r_stall_cnt + SC_W'(1);
    end

    // Sticky per-port stall flags, set on the STALL_LIMIT-th starved cycle.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_stall_flag <= 2'b00;
        end else if (clr) begin
            r_stall_flag <= 2'b00;
        end else if (w_stall_hit) begin
            if (r_state == GNT0) r_stall_flag[0] <= 1'b1;
            if (r_state == GNT1) r_stall_flag[1] <= 1'b1;
        end
    end

    // Registered interrupt, trails the flags by one cycle.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) r_irq <= 1'b0;
        else if (clr)      r_irq <= 1'b0;
        else               r_irq <= |r_stall_flag;
    end

    assign M_AXIS_TDATA   = w_m_tdata;
    assign M_AXIS_TVALID  = w_m_tvalid;
    assign M_AXIS_TLAST   = w_m_tlast;
    assign S0_AXIS_TREADY = w_s0_tready;
    assign S1_AXIS_TREADY = w_s1_tready;
    assign pkt_cnt0       = r_pkt_cnt0;
    assign pkt_cnt1       = r_pkt_cnt1;
    assign stall_flag     = r_stall_flag;
    assign grant_dbg      = {r_state == GNT1, r_state == GNT0};
    assign irq            = r_irq;

endmodule

// File: tb/tb_vita49_unpack_arb.sv
// Directed bench for vita49_unpack_arb. Sources are queue-driven AXI-Stream
// masters and a monitor logs output beats with their cycle number. The
// counter width is narrowed to 8 so the wrap case fits in a short run.
module tb_vita49_unpack_arb;
    localparam int CW = 8;
    localparam int SL = 1024;

    logic          AXIS_ACLK = 1'b0;
    logic          AXIS_ARESETN;
    logic [31:0]   S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
    logic          S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
    logic          S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
    logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic [1:0]    port_en;
    logic          clr;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic [1:0]    stall_flag, grant_dbg;
    logic          irq;

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    vita49_unpack_arb #(.CNT_WIDTH(CW), .STALL_LIMIT(SL)) dut (
        .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
        .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TVALID(S0_AXIS_TVALID),
        .S0_AXIS_TLAST(S0_AXIS_TLAST), .S0_AXIS_TREADY(S0_AXIS_TREADY),
        .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TVALID(S1_AXIS_TVALID),
        .S1_AXIS_TLAST(S1_AXIS_TLAST), .S1_AXIS_TREADY(S1_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .port_en(port_en), .clr(clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .stall_flag(stall_flag), .grant_dbg(grant_dbg), .irq(irq)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } beat_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        m_toggle = 1'b0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    beat_t       mon[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        logic [32:0] e;
        e = (q0.size() > 0) ? q0[0] : 33'd0;
        S0_AXIS_TVALID = (q0.size() > 0);
        S0_AXIS_TDATA  = e[31:0];
        S0_AXIS_TLAST  = e[32];
        e = (q1.size() > 0) ? q1[0] : 33'd0;
        S1_AXIS_TVALID = (q1.size() > 0);
        S1_AXIS_TDATA  = e[31:0];
        S1_AXIS_TLAST  = e[32];
    endtask

    // Called with signals settled; logs this cycle's handshakes, crosses one
    // edge, then drives the next cycle and lets it settle.
    task automatic cycle();
        logic hs0, hs1;
        hs0 = S0_AXIS_TVALID & S0_AXIS_TREADY;
        hs1 = S1_AXIS_TVALID & S1_AXIS_TREADY;
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            mon.push_back('{d: M_AXIS_TDATA, l: M_AXIS_TLAST, c: cyc});
        @(posedge AXIS_ACLK);
        #1;
        if (hs0) q0.delete(0);
        if (hs1) q1.delete(0);
        if (m_toggle) M_AXIS_TREADY = ~M_AXIS_TREADY;
        drive_srcs();
        #1;
        cyc++;
    endtask

    task automatic push_pkt(input int port, input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            if (port == 0) q0.push_back({(i == len - 1), base + 32'(i)});
            else           q1.push_back({(i == len - 1), base + 32'(i)});
        end
    endtask

    task automatic run_until(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (mon.size() < n && k < limit) begin
            cycle();
            k++;
        end
        check(tag, 32'(mon.size() >= n), 32'd1);
    endtask

    initial begin
        int          first;
        logic [31:0] exp_d;

        AXIS_ARESETN   = 1'b0;
        S0_AXIS_TDATA  = '0; S0_AXIS_TVALID = 1'b1; S0_AXIS_TLAST = 1'b0;
        S1_AXIS_TDATA  = '0; S1_AXIS_TVALID = 1'b1; S1_AXIS_TLAST = 1'b0;
        M_AXIS_TREADY  = 1'b1;
        port_en        = 2'b11;
        clr            = 1'b0;
        repeat (3) @(posedge AXIS_ACLK);
        #2;
        // reset state, with both sources requesting
        check("rst_grant", 32'(grant_dbg), 32'd0);
        check("rst_s0rdy", 32'(S0_AXIS_TREADY), 32'd0);
        check("rst_s1rdy", 32'(S1_AXIS_TREADY), 32'd0);
        check("rst_mvld",  32'(M_AXIS_TVALID), 32'd0);
        check("rst_cnt0",  32'(pkt_cnt0), 32'd0);
        check("rst_cnt1",  32'(pkt_cnt1), 32'd0);
        check("rst_stall", 32'(stall_flag), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        AXIS_ARESETN = 1'b1;

        // A: alternating 4-beat packets, port 0 wins the first tie
        push_pkt(0, 32'hA000, 4); push_pkt(1, 32'hB000, 4);
        push_pkt(0, 32'hA010, 4); push_pkt(1, 32'hB010, 4);
        drive_srcs();
        #1;
        cycle();
        check("A_first_arb", 32'(grant_dbg), 32'd1);
        run_until("A_timeout", 16, 60);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 4; i++) begin
                exp_d = ((p % 2) ? 32'hB000 : 32'hA000) + 32'((p / 2) * 16 + i);
                check("A_data", mon[p * 4 + i].d, exp_d);
            end
        check("A_last3",   32'(mon[3].l), 32'd1);
        check("A_last2",   32'(mon[2].l), 32'd0);
        check("A_burst",   32'(mon[3].c - mon[0].c), 32'd3);
        check("A_bubble",  32'(mon[4].c - mon[3].c), 32'd2);
        check("A_span",    32'(mon[15].c - mon[0].c), 32'd18);
        check("A_cnt0",    32'(pkt_cnt0), 32'd2);
        check("A_cnt1",    32'(pkt_cnt1), 32'd2);

        // B: S0 requests while S1 is mid-packet; it must wait for S1's TLAST
        mon.delete();
        push_pkt(1, 32'hB100, 4);
        drive_srcs();
        #1;
        run_until("B_timeout", 2, 10);
        push_pkt(0, 32'hA100, 2);
        drive_srcs();
        #1;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            if (S0_AXIS_TREADY && first < 0) first = cyc;
            cycle();
        end
        check("B_s1_last", mon[3].d, 32'hB103);
        check("B_s1_lastf", 32'(mon[3].l), 32'd1);
        check("B_s0_wait", 32'(first - mon[3].c), 32'd2);
        check("B_s0_data", mon[4].d, 32'hA100);

        // C: backpressure toggling every cycle over a 6-beat packet
        mon.delete();
        push_pkt(0, 32'hC000, 6);
        m_toggle = 1'b1;
        drive_srcs();
        #1;
        run_until("C_timeout", 6, 40);
        m_toggle = 1'b0;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 6; i++) check("C_data", mon[i].d, 32'hC000 + 32'(i));
        check("C_last5", 32'(mon[5].l), 32'd1);
        check("C_last4", 32'(mon[4].l), 32'd0);
        check("C_stall", 32'(stall_flag), 32'd0);

        // D: starvation mid-packet in GNT0
        mon.delete();
        q0.push_back({1'b0, 32'hD000});
        drive_srcs();
        #1;
        run_until("D_timeout", 1, 10);
        repeat (SL - 1) cycle();
        check("D_pre_flag", 32'(stall_flag), 32'd0);
        cycle();
        check("D_flag",  32'(stall_flag), 32'd1);
        check("D_irq0",  32'(irq), 32'd0);
        check("D_hold",  32'(grant_dbg), 32'd1);
        cycle();
        check("D_irq1",  32'(irq), 32'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("D_clr_flag", 32'(stall_flag), 32'd0);
        check("D_clr_irq",  32'(irq), 32'd0);
        check("D_clr_cnt0", 32'(pkt_cnt0), 32'd0);
        check("D_clr_cnt1", 32'(pkt_cnt1), 32'd0);
        q0.push_back({1'b1, 32'hD001});
        drive_srcs();
        #1;
        run_until("D_timeout2", 2, 10);
        check("D_tail", mon[1].d, 32'hD001);
        check("D_cnt0", 32'(pkt_cnt0), 32'd1);

        // E: counter wrap with single-beat packets, then clr vs increment
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        mon.delete();
        for (int i = 0; i < 255; i++) q0.push_back({1'b1, 32'hE0000 + 32'(i)});
        drive_srcs();
        #1;
        run_until("E_timeout", 255, 600);
        check("E_cnt_ff", 32'(pkt_cnt0), 32'hFF);
        push_pkt(0, 32'hE1000, 1);
        drive_srcs();
        #1;
        run_until("E_timeout2", 256, 10);
        check("E_wrap", 32'(pkt_cnt0), 32'd0);
        push_pkt(0, 32'hE2000, 1);
        drive_srcs();
        #1;
        run_until("E_timeout3", 257, 10);
        check("E_single", 32'(pkt_cnt0), 32'd1);
        push_pkt(0, 32'hE3000, 1);
        drive_srcs();
        #1;
        for (int k = 0; k < 10 && grant_dbg != 2'b01; k++) cycle();
        check("E_gnt", 32'(grant_dbg), 32'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("E_clr_beat", 32'(mon.size()), 32'd258);
        check("E_clr_wins", 32'(pkt_cnt0), 32'd0);

        // G: disabling port 0 mid-packet lets it finish but blocks a new grant
        mon.delete();
        push_pkt(0, 32'hE400, 4);
        drive_srcs();
        #1;
        run_until("G_timeout", 1, 10);
        port_en = 2'b10;
        run_until("G_timeout2", 4, 10);
        check("G_last", mon[3].d, 32'hE403);
        check("G_cnt0", 32'(pkt_cnt0), 32'd1);
        push_pkt(0, 32'hE500, 2);
        drive_srcs();
        #1;
        repeat (6) cycle();
        check("G_blocked", 32'(mon.size()), 32'd4);
        check("G_idle",    32'(grant_dbg), 32'd0);
        port_en = 2'b11;
        run_until("G_timeout3", 6, 10);
        check("G_resume", mon[4].d, 32'hE500);

        // F: reset at beat 3 of 8; last_grant returns to 1 so port 0 wins the tie
        mon.delete();
        push_pkt(0, 32'hF000, 8);
        drive_srcs();
        #1;
        run_until("F_timeout", 2, 10);
        check("F_pre", 32'(grant_dbg), 32'd1);
        AXIS_ARESETN = 1'b0;
        #1;
        check("F_grant", 32'(grant_dbg), 32'd0);
        check("F_s0rdy", 32'(S0_AXIS_TREADY), 32'd0);
        check("F_mvld",  32'(M_AXIS_TVALID), 32'd0);
        check("F_cnt0",  32'(pkt_cnt0), 32'd0);
        q0.delete();
        drive_srcs();
        repeat (2) cycle();
        check("F_dropped", 32'(mon.size()), 32'd2);
        AXIS_ARESETN = 1'b1;
        push_pkt(0, 32'hF100, 2);
        push_pkt(1, 32'hF200, 2);
        drive_srcs();
        #1;
        run_until("F_timeout2", 6, 20);
        check("F_tie0", mon[2].d, 32'hF100);
        check("F_tie1", mon[4].d, 32'hF200);
        check("F_cnt0b", 32'(pkt_cnt0), 32'd1);
        check("F_cnt1b", 32'(pkt_cnt1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
